// File: rtl/tag_regfile_pkg.sv
// Shared types for the renaming register file: CDB broadcast and per-register entry.
package tag_regfile_pkg;

  localparam int unsigned RF_WIDTH    = 32;
  localparam int unsigned RF_TAG_W    = 4;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned REG_ADDR_W  = $clog2(RF_NUM_REGS);

  typedef struct packed {
    logic                valid;
    logic [RF_TAG_W-1:0] tag;
    logic [RF_WIDTH-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic [RF_WIDTH-1:0] data;
    logic [RF_TAG_W-1:0] tag;
    logic                busy;
  } reg_entry_t;

endpackage

// File: rtl/tag_regfile_rdport.sv
// One source read port: returns data, the producer tag, or a same-cycle CDB bypass.
module tag_regfile_rdport
  import tag_regfile_pkg::*;
#(
  parameter int unsigned NUM_CDB = 2
) (
  input  reg_entry_t                entry,
  input  cdb_t       [NUM_CDB-1:0]  cdb,
  output logic                      rd_busy,
  output logic       [RF_WIDTH-1:0] rd_value
);

  always_comb begin
    rd_busy  = 1'b0;
    rd_value = '0;
    if (entry.busy) begin
      rd_busy  = 1'b1;
      rd_value = RF_WIDTH'(entry.tag);
      // Descending scan so the lowest-index matching port has the final say.
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb[c].valid && (cdb[c].tag == entry.tag)) begin
          rd_busy  = 1'b0;
          rd_value = cdb[c].data;
        end
      end
    end else begin
      rd_value = entry.data;
    end
  end

endmodule

// File: rtl/tag_regfile.sv
// Architectural register file with rename tags, multi-port CDB commit, bypass and flush.
module tag_regfile
  import tag_regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned TAG_W    = RF_TAG_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_CDB  = 2,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB-1:0][WIDTH-1:0]  cdb_data,
  input  logic                           alloc_valid,
  input  logic [AW-1:0]                  alloc_rd,
  input  logic [TAG_W-1:0]               alloc_tag,
  input  logic                           flush,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0]              rd_busy,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_value,
  output logic [NUM_REGS-1:0]            busy_vec
);

  cdb_t       [NUM_CDB-1:0] cdb;
  reg_entry_t               regs_q [NUM_REGS];
  reg_entry_t               regs_d [NUM_REGS];

  always_comb begin
    for (int c = 0; c < NUM_CDB; c++) begin
      cdb[c].valid = cdb_valid[c];
      cdb[c].tag   = cdb_tag[c];
      cdb[c].data  = cdb_data[c];
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (regs_q[i].busy) begin
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
          if (cdb[c].valid && (cdb[c].tag == regs_q[i].tag)) begin
            regs_d[i].data = cdb[c].data;
            regs_d[i].busy = 1'b0;
          end
        end
      end
      // Commit data above survives; only the busy/tag fields are overridden here.
      if (flush) begin
        regs_d[i].busy = 1'b0;
      end else if (alloc_valid && (alloc_rd == AW'(i))) begin
        regs_d[i].busy = 1'b1;
        regs_d[i].tag  = alloc_tag;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = regs_q[i].busy;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    tag_regfile_rdport #(
      .NUM_CDB(NUM_CDB)
    ) u_rdport (
      .entry   (regs_q[rd_addr[p]]),
      .cdb     (cdb),
      .rd_busy (rd_busy[p]),
      .rd_value(rd_value[p])
    );
  end

endmodule
